// File: rtl/rom_pipelined_adder_pkg.sv
// rom_adder_pkg: shared sizing helpers and ROM entry layout for the pipelined ROM adder.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
//   total_width()    - adder width built from SLICE_WIDTH * NUM_SLICES
//   rom_addr_width() - slice ROM address width, {cin, a_s, b_s} = 2*SLICE_WIDTH+1
//   rom_entry_t      - {cout, sum} entry layout at the default slice width

package rom_adder_pkg;

  localparam int DEF_SLICE_WIDTH = 4;
  localparam int DEF_NUM_SLICES  = 4;

  function automatic int total_width(input int slice_width, input int num_slices);
    return slice_width * num_slices;
  endfunction

  function automatic int rom_addr_width(input int slice_width);
    return 2 * slice_width + 1;
  endfunction

  // Entry layout: carry-out above the slice sum. Each slice LUT uses the
  // same {cout, sum} ordering at its own SLICE_WIDTH.
  typedef struct packed {
    logic                       cout;
    logic [DEF_SLICE_WIDTH-1:0] sum;
  } rom_entry_t;

endpackage

// File: rtl/rom_pipelined_adder_if.sv
// rom_pipelined_adder_if: operand and result channels of the pipelined ROM adder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both channels; in_ready is driven by the adder.
//   in_valid/in_ready/a/b/cin - operand channel (master -> adder)
//   out_valid/out_ready/sum   - result channel (adder -> master), sum = {cout, a+b+cin}
//   ovf                       - signed overflow, only when ROM_ADDER_OVF_EN is defined

interface rom_pipelined_adder_if #(
  parameter int SLICE_WIDTH = 4,
  parameter int NUM_SLICES  = 4
);
  import rom_adder_pkg::*;

  localparam int TW = total_width(SLICE_WIDTH, NUM_SLICES);

  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [TW:0]   sum;
`ifdef ROM_ADDER_OVF_EN
  logic          ovf;
`endif

  // Source/sink side (testbench or surrounding datapath).
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum
`ifdef ROM_ADDER_OVF_EN
    , input ovf
`endif
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum
`ifdef ROM_ADDER_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/rom_pipelined_adder_rom_slice.sv
// rom_slice_lut: constant truth table for one slice, {cout_s, sum_s} = a_s + b_s + cin_s.
// Latency: 0 cycles (combinational read).
// Backpressure: none; pure lookup.
//   addr_i - {cin_s, a_s, b_s}
//   data_o - {cout_s, sum_s}, SLICE_WIDTH+1 bits

module rom_slice_lut #(
  parameter int SLICE_WIDTH = 4
) (
  input  logic [rom_adder_pkg::rom_addr_width(SLICE_WIDTH)-1:0] addr_i,
  output logic [SLICE_WIDTH:0]                                  data_o
);
  import rom_adder_pkg::*;

  localparam int SW    = SLICE_WIDTH;
  localparam int AW    = rom_addr_width(SLICE_WIDTH);
  localparam int DEPTH = 1 << AW;
  localparam int MASK  = (1 << SW) - 1;

  logic [SW:0] rom [DEPTH];

  // Table contents are derived from the address fields at elaboration time,
  // so every entry is a constant and synthesis folds this into a ROM.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam int CIN_V = i >> (2 * SW);
    localparam int A_V   = (i >> SW) & MASK;
    localparam int B_V   = i & MASK;
    localparam logic [SW:0] ENTRY = (SW + 1)'(A_V + B_V + CIN_V);
    assign rom[i] = ENTRY;
  end

  assign data_o = rom[addr_i];

endmodule

// File: rtl/rom_pipelined_adder.sv
// rom_pipelined_adder: TOTAL_WIDTH adder built from NUM_SLICES ROM slices, one register stage per slice.
// Latency: NUM_SLICES cycles from accept to out_valid; one result per cycle when unstalled.
// Backpressure: global stall, in_ready = !out_valid || out_ready; every stage holds while stalled.
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   bus        - rom_pipelined_adder_if.slave (operands in, {cout, sum} out)
//   Optional: ROM_ADDER_OVF_EN adds a registered signed-overflow flag on bus.ovf.

module rom_pipelined_adder #(
  parameter int SLICE_WIDTH = 4,
  parameter int NUM_SLICES  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  rom_pipelined_adder_if.slave bus
);
  import rom_adder_pkg::*;

  localparam int SW = SLICE_WIDTH;
  localparam int NS = NUM_SLICES;
  localparam int TW = total_width(SLICE_WIDTH, NUM_SLICES);
  localparam int AW = rom_addr_width(SLICE_WIDTH);

  logic en;
  logic out_vld;

  // One enable for the whole pipeline: it only moves when the output
  // register is empty or being drained this cycle.
  assign en           = !out_vld || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    // Operand bits still unconsumed on entry to this stage: slice k and up.
    localparam int SRC_W = TW - k * SW;

    logic [SRC_W-1:0]     a_src;
    logic [SRC_W-1:0]     b_src;
    logic                 c_src;
    logic                 v_src;
    logic [AW-1:0]        lut_addr;
    logic [SW:0]          lut_dat;
    // Sum slices 0..k, assembled lowest slice first.
    logic [(k+1)*SW-1:0]  acc_d;
    logic [(k+1)*SW-1:0]  acc_q;
    logic                 carry_q;
    logic                 valid_q;

    if (k == 0) begin : g_src
      assign a_src = bus.a;
      assign b_src = bus.b;
      assign c_src = bus.cin;
      // Loads only when en is high, and in_ready == en, so this is in_valid && in_ready.
      assign v_src = bus.in_valid;
      assign acc_d = lut_dat[SW-1:0];
    end else begin : g_src
      assign a_src = g_stage[k-1].g_skew.a_hi_q;
      assign b_src = g_stage[k-1].g_skew.b_hi_q;
      assign c_src = g_stage[k-1].carry_q;
      assign v_src = g_stage[k-1].valid_q;
      assign acc_d = {lut_dat[SW-1:0], g_stage[k-1].acc_q};
    end

    assign lut_addr = {c_src, a_src[SW-1:0], b_src[SW-1:0]};

    rom_slice_lut #(
      .SLICE_WIDTH (SW)
    ) u_lut (
      .addr_i (lut_addr),
      .data_o (lut_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q   <= '0;
        carry_q <= 1'b0;
        valid_q <= 1'b0;
      end else if (en) begin
        acc_q   <= acc_d;
        carry_q <= lut_dat[SW];
        valid_q <= v_src;
      end
    end

    // Skew registers: upper operand slices travel alongside the carry so
    // that each stage sees the slice belonging to the same transaction.
    // The last stage has nothing left to forward.
    if (k < NS - 1) begin : g_skew
      logic [SRC_W-SW-1:0] a_hi_q;
      logic [SRC_W-SW-1:0] b_hi_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (en) begin
          a_hi_q <= a_src[SRC_W-1:SW];
          b_hi_q <= b_src[SRC_W-1:SW];
        end
      end
    end
  end

  assign out_vld       = g_stage[NS-1].valid_q;
  assign bus.out_valid = out_vld;
  assign bus.sum       = {g_stage[NS-1].carry_q, g_stage[NS-1].acc_q};

`ifdef ROM_ADDER_OVF_EN
  // The operand MSBs reach the last stage through the skew registers, so
  // overflow is formed next to the top slice and registered with it.
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = (g_stage[NS-1].a_src[SW-1] == g_stage[NS-1].b_src[SW-1]) &&
                 (g_stage[NS-1].lut_dat[SW-1] != g_stage[NS-1].a_src[SW-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_rom_pipelined_adder.sv
// tb_rom_pipelined_adder: table-driven and sequence checks of rom_pipelined_adder (4x4-bit slices).
// Latency: expects results NUM_SLICES cycles after accept.
// Backpressure: exercises out_ready stalls, back-to-back flow and mid-stream reset.

module tb_rom_pipelined_adder;
  import rom_adder_pkg::*;

  localparam int SW = 4;
  localparam int NS = 4;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_pipelined_adder_if #(.SLICE_WIDTH(SW), .NUM_SLICES(NS)) bus ();

  rom_pipelined_adder #(.SLICE_WIDTH(SW), .NUM_SLICES(NS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [TW:0] sum;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    logic [TW:0]   sum;
    logic          ovf;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int stall_seen = 0;
  int c0;
  bit bp_seen;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [TW:0] model_sum(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                            input logic cin);
    return {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, cin};
  endfunction

  function automatic logic model_ovf(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                     input logic cin);
    logic [TW:0] s;
    s = model_sum(a, b, cin);
    return (a[TW-1] == b[TW-1]) && (s[TW-1] != a[TW-1]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a transfer happens at the next rising edge whenever
  // out_valid && out_ready is seen mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: sum 0x%0h with nothing outstanding", bus.sum);
      end else begin
        e = sb.pop_front();
        check("sb_sum", 64'(bus.sum), 64'(e.sum));
`ifdef ROM_ADDER_OVF_EN
        check("sb_ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
      end
    end
  end

  // Offer one operand pair until accepted; the expected result enters the
  // scoreboard in the cycle the handshake completes.
  task automatic send(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                      input logic [TW:0] exp_s, input logic exp_o);
    bit   done;
    exp_t e;
    done = 1'b0;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        e.sum = exp_s;
        e.ovf = exp_o;
        sb.push_back(e);
        done = 1'b1;
      end else begin
        stall_seen++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: operands 0x%0h+0x%0h never accepted", a, b);
    end
  endtask

  task automatic send_rand();
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    a = TW'($urandom);
    b = TW'($urandom);
    cin = 1'($urandom_range(0, 1));
    send(a, b, cin, model_sum(a, b, cin), model_ovf(a, b, cin));
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (sb.size() != 0 || bus.out_valid === 1'b1); i++) begin
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Single transaction into an empty pipeline, checking the exact cycle it appears.
  task automatic lat_check(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                           input logic [TW:0] exp_s, input logic exp_o);
    exp_t e;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("lat_in_ready", 64'(bus.in_ready), 64'd1);
    e.sum = exp_s;
    e.ovf = exp_o;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < NS - 1; i++) begin
      @(negedge clk);
      check("lat_early_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    check("lat_sum", 64'(bus.sum), 64'(exp_s));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b1;

    // Exhaustive low slice, then hand-picked corners with literal results.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        v.a = TW'(ia);
        v.b = TW'(ib);
        v.cin = 1'b0;
        v.sum = (TW + 1)'(ia + ib);
        v.ovf = 1'b0;
        vecs.push_back(v);
      end
    end
    vecs.push_back('{16'h000F, 16'h000F, 1'b0, 17'h0001E, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 17'h00001, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b0});
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1});
    vecs.push_back('{16'h7FFF, 16'h8000, 1'b0, 17'h0FFFF, 1'b0});

    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef ROM_ADDER_OVF_EN
    check("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].ovf);
    drain();

    // Full carry ripple through all four slices.
    lat_check(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0);
    lat_check(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b0);

    // Back-to-back: 256 accepts in 256 cycles, never refused.
    stall_seen = 0;
    c0 = cyc;
    repeat (256) send_rand();
    check("b2b_cycles", 64'(cyc - c0), 64'd256);
    check("b2b_in_ready_low", 64'(stall_seen), 64'd0);
    drain();

    // Backpressure with a full pipeline.
    bp_seen = 1'b0;
    fork
      begin
        repeat (12) send_rand();
      end
      begin
        for (int i = 0; i < 50 && !bp_seen; i++) begin
          @(negedge clk);
          if (bus.out_valid === 1'b1) bp_seen = 1'b1;
        end
        check("bp_pipe_filled", 64'(bp_seen), 64'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_out_valid", 64'(bus.out_valid), 64'd1);
          check("bp_sum_held", 64'(bus.sum), 64'(sb[0].sum));
          check("bp_in_ready", 64'(bus.in_ready), 64'd0);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with work in flight and a result at the output.
    repeat (4) send_rand();
    check("rst_pre_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_sum", 64'(bus.sum), 64'd0);
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lat_check(16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
